// File: rtl/lcd_frame_streamer.sv
// Streams one PAGES x COLS frame of pattern bytes per key change, with ready/valid handshake.
// Optional build macro LCD_FRAME_CNT_EN adds an 8-bit completed-frame counter output.
module lcd_frame_streamer #(
   parameter int PAGES = 8,
   parameter int COLS  = 64
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] key,
   input  logic       en,
   output logic [7:0] data_out,
   output logic       data_valid,
   output logic       frame_busy,
`ifdef LCD_FRAME_CNT_EN
   output logic       frame_done,
   output logic [7:0] frame_cnt
`else
   output logic       frame_done
`endif
);

   localparam int PW = (PAGES > 1) ? $clog2(PAGES) : 1;
   localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
   localparam logic [PW-1:0] PAGE_LAST = PW'(PAGES - 1);
   localparam logic [CW-1:0] COL_LAST  = CW'(COLS - 1);

   typedef enum logic [1:0] {IDLE, LOAD, STREAM, DONE} state_t;

   state_t        state_q, state_d;
   logic [3:0]    cur_key_q, cur_key_d;
   logic [3:0]    prev_key_q, prev_key_d;
   logic          pending_q, pending_d;
   logic [PW-1:0] page_q, page_d;
   logic [CW-1:0] col_q, col_d;
   logic [7:0]    data_out_q, data_out_d;
   logic          data_valid_q, data_valid_d;
   logic          frame_busy_q, frame_busy_d;
   logic          frame_done_q, frame_done_d;
   logic          key_change;
   logic          xfer;

   function automatic logic [7:0] pattern(input logic [3:0] k, input logic [PW-1:0] pg,
                                          input logic [CW-1:0] c);
      logic [7:0] pg8;
      logic [7:0] c8;
      pg8 = 8'(pg);
      c8  = 8'(c);
      case (k)
         4'd0:    pattern = 8'h00;
         4'd1:    pattern = 8'hFF;
         4'd2:    pattern = c8[0] ? 8'hAA : 8'h55;
         4'd3:    pattern = c8[3] ? 8'hFF : 8'h00;
         4'd4:    pattern = pg8[0] ? 8'hFF : 8'h00;
         4'd5:    pattern = {pg8[2:0], c8[4:0]};
         default: pattern = {k, k};
      endcase
   endfunction

   always_comb begin
      state_d    = state_q;
      cur_key_d  = cur_key_q;
      page_d     = page_q;
      col_d      = col_q;
      prev_key_d = key;
      key_change = (key != prev_key_q);
      pending_d  = pending_q | key_change;
      xfer       = data_valid_q & en;

      case (state_q)
         IDLE: begin
            if (pending_q || key_change) state_d = LOAD;
         end
         LOAD: begin
            // The key latched here is the newest value, so a change seen now is already served.
            cur_key_d = key;
            pending_d = 1'b0;
            page_d    = '0;
            col_d     = '0;
            state_d   = STREAM;
         end
         STREAM: begin
            if (xfer) begin
               if (col_q == COL_LAST) begin
                  col_d = '0;
                  if (page_q == PAGE_LAST) state_d = DONE;
                  else                     page_d  = page_q + 1'b1;
               end else begin
                  col_d = col_q + 1'b1;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Outputs are registered, so they are derived from the state being entered.
      data_valid_d = (state_d == STREAM);
      data_out_d   = (state_d == STREAM) ? pattern(cur_key_d, page_d, col_d) : 8'h00;
      frame_busy_d = (state_d == LOAD) || (state_d == STREAM);
      frame_done_d = (state_d == DONE);
   end

`ifdef LCD_FRAME_CNT_EN
   logic [7:0] frame_cnt_q, frame_cnt_d;

   always_comb begin
      frame_cnt_d = frame_done_q ? frame_cnt_q + 8'd1 : frame_cnt_q;
   end

   always_ff @(posedge clk) begin
      if (rst) frame_cnt_q <= 8'd0;
      else     frame_cnt_q <= frame_cnt_d;
   end

   assign frame_cnt = frame_cnt_q;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         cur_key_q    <= 4'd0;
         prev_key_q   <= key;
         pending_q    <= 1'b1;
         page_q       <= '0;
         col_q        <= '0;
         data_out_q   <= 8'h00;
         data_valid_q <= 1'b0;
         frame_busy_q <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cur_key_q    <= cur_key_d;
         prev_key_q   <= prev_key_d;
         pending_q    <= pending_d;
         page_q       <= page_d;
         col_q        <= col_d;
         data_out_q   <= data_out_d;
         data_valid_q <= data_valid_d;
         frame_busy_q <= frame_busy_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign data_out   = data_out_q;
   assign data_valid = data_valid_q;
   assign frame_busy = frame_busy_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_lcd_frame_streamer.sv
// Scoreboard bench for lcd_frame_streamer: expected frames are queued when keys are driven
// and compared byte by byte as the DUT hands them over.
module tb_lcd_frame_streamer;

   localparam int PAGES  = 8;
   localparam int COLS   = 64;
   localparam int NBYTES = PAGES * COLS;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] key = 4'd1;
   logic       en  = 1'b1;
   logic [7:0] data_out;
   logic       data_valid;
   logic       frame_busy;
   logic       frame_done;
`ifdef LCD_FRAME_CNT_EN
   logic [7:0] frame_cnt;
`endif

   int   checks    = 0;
   int   failures  = 0;
   int   xfer_cnt  = 0;
   int   done_cnt  = 0;
   bit   last_final = 1'b0;
   bit   stalled   = 1'b0;
   bit   toggle_en = 1'b0;
   logic [7:0] held;
   logic [7:0] sb[$];

   lcd_frame_streamer #(.PAGES(PAGES), .COLS(COLS)) dut (
      .clk        (clk),
      .rst        (rst),
      .key        (key),
      .en         (en),
      .data_out   (data_out),
      .data_valid (data_valid),
      .frame_busy (frame_busy),
`ifdef LCD_FRAME_CNT_EN
      .frame_done (frame_done),
      .frame_cnt  (frame_cnt)
`else
      .frame_done (frame_done)
`endif
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [7:0] exp_byte(input int k, input int pg, input int c);
      logic [3:0] k4;
      k4 = 4'(k);
      case (k)
         0:       return 8'h00;
         1:       return 8'hFF;
         2:       return (c % 2 == 1) ? 8'hAA : 8'h55;
         3:       return ((c / 8) % 2 == 1) ? 8'hFF : 8'h00;
         4:       return (pg % 2 == 1) ? 8'hFF : 8'h00;
         5:       return 8'(((pg % 8) * 32) + (c % 32));
         default: return {k4, k4};
      endcase
   endfunction

   task automatic push_frame(input int k);
      for (int pg = 0; pg < PAGES; pg++)
         for (int c = 0; c < COLS; c++)
            sb.push_back(exp_byte(k, pg, c));
      $display("push frame key=%0d bytes=%0d queued=%0d", k, NBYTES, sb.size());
   endtask

   task automatic wait_done(input int budget);
      int start;
      start = done_cnt;
      for (int i = 0; i < budget && done_cnt == start; i++) @(posedge clk);
      check_eq("frame_done_timeout", done_cnt, start + 1);
      $display("frame done count=%0d", done_cnt);
   endtask

   task automatic wait_xfer(input int n);
      for (int i = 0; i < 4 * NBYTES && xfer_cnt < n; i++) @(posedge clk);
      check_eq("xfer_reach", (xfer_cnt >= n), 1);
      #1;
   endtask

   // en driver: held high, or toggled every cycle when requested.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         en = toggle_en ? ~en : 1'b1;
      end
   end

   // Monitor: scoreboard compare on every transfer, stall stability, frame_done placement.
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            xfer_cnt   = 0;
            last_final = 1'b0;
            stalled    = 1'b0;
         end else begin
            if (stalled) begin
               check_eq("stall_valid", data_valid, 1);
               check_eq("stall_data", data_out, held);
            end
            if (frame_done) begin
               check_eq("done_after_last", last_final, 1);
               check_eq("done_valid", data_valid, 0);
               check_eq("done_busy", frame_busy, 0);
               done_cnt++;
               xfer_cnt = 0;
            end
            last_final = 1'b0;
            if (data_valid && en) begin
               check_eq("sb_nonempty", (sb.size() != 0), 1);
               if (sb.size() != 0) check_eq("byte", data_out, sb.pop_front());
               xfer_cnt++;
               if (xfer_cnt == NBYTES) last_final = 1'b1;
               stalled = 1'b0;
            end else if (data_valid) begin
               stalled = 1'b1;
               held    = data_out;
            end else begin
               stalled = 1'b0;
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state with key=1 held.
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_valid", data_valid, 0);
      check_eq("rst_data", data_out, 8'h00);
      check_eq("rst_busy", frame_busy, 0);
      check_eq("rst_done", frame_done, 0);
      push_frame(1);
      @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_eq("load_busy", frame_busy, 1);
      check_eq("load_valid", data_valid, 0);
      @(negedge clk);
      check_eq("first_valid", data_valid, 1);
      wait_done(NBYTES + 20);
      @(negedge clk);
      check_eq("post_frame_valid", data_valid, 0);
      repeat (5) @(posedge clk);
      check_eq("idle_valid", data_valid, 0);

      // key=2 with en toggling every cycle.
      #1;
      toggle_en = 1'b1;
      key = 4'd2;
      push_frame(2);
      wait_done(3 * NBYTES);
      #1 toggle_en = 1'b0;
      repeat (5) @(posedge clk);

      // key 5, changed to 9 at transfer 100: current frame finishes with key 5.
      #1 key = 4'd5;
      push_frame(5);
      wait_xfer(100);
      key = 4'd9;
      push_frame(9);
      wait_done(NBYTES + 20);
      wait_done(NBYTES + 20);
      repeat (5) @(posedge clk);

      // Several key changes in one frame collapse into one following frame.
      #1 key = 4'd3;
      push_frame(3);
      wait_xfer(50);
      key = 4'd4;
      wait_xfer(150);
      key = 4'd7;
      push_frame(7);
      wait_done(NBYTES + 20);
      wait_done(NBYTES + 20);
      repeat (20) @(posedge clk);
      @(negedge clk);
      check_eq("no_extra_frame", data_valid, 0);
      check_eq("sb_drained", sb.size(), 0);

      // Reset in the middle of a frame abandons it and restarts from page 0, col 0.
      @(posedge clk);
      #1 key = 4'd6;
      push_frame(6);
      wait_xfer(200);
      rst = 1'b1;
      @(negedge clk);
      #1;
      sb.delete();
      push_frame(6);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_eq("midrst_valid", data_valid, 0);
      check_eq("midrst_busy", frame_busy, 0);
      wait_done(NBYTES + 20);
      repeat (5) @(posedge clk);
      @(negedge clk);
      check_eq("final_sb_drained", sb.size(), 0);
`ifdef LCD_FRAME_CNT_EN
      check_eq("frame_cnt", frame_cnt, 1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/lcd_frame_streamer.md
LCD_FRAME_STREAMER -- requirements
Module: lcd_frame_streamer

Interface
REQ-001 Parameter PAGES, default 8, number of 8-row pages per frame (power of two, 1..8).
REQ-002 Parameter COLS, default 64, columns per page (power of two, 8..64).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 key  input  4  pattern select from the autokey stage; sampled every cycle.
REQ-006 en  input  1  ready from the LCD controller (its en_tran); high = byte may be accepted this cycle.
REQ-007 data_out  output  8  pixel byte for the current (page, col).
REQ-008 data_valid  output  1  data_out holds a valid byte awaiting acceptance.
REQ-009 frame_busy  output  1  high from frame start until the last byte is accepted.
REQ-010 frame_done  output  1  one-cycle pulse in the cycle after the last byte of a frame is accepted.

Function
REQ-011 Byte transfer SHALL occur exactly in cycles where data_valid=1 and en=1; data_out and data_valid SHALL stay stable while data_valid=1 and en=0.
REQ-012 State machine SHALL have states IDLE, LOAD, STREAM, DONE.
REQ-013 IDLE -> LOAD when pending=1; LOAD latches key into cur_key, clears pending, zeroes page/col and goes to STREAM in one cycle.
REQ-014 In STREAM, data_valid=1 and data_out = pattern(cur_key, page, col); the first byte appears in the cycle after LOAD (latency 1 from LOAD, 2 from a key change in IDLE).
REQ-015 On each transfer, col increments; at col=COLS-1 col wraps to 0 and page increments; a transfer at page=PAGES-1, col=COLS-1 moves to DONE.
REQ-016 DONE SHALL last one cycle, drive frame_done=1 and data_valid=0, then go to IDLE.
REQ-017 pattern: key 0 -> 0x00; 1 -> 0xFF; 2 -> col[0]?0xAA:0x55; 3 -> col[3]?0xFF:0x00; 4 -> page[0]?0xFF:0x00; 5 -> {page[2:0], col[4:0]}; 6..15 -> {key, key}.
REQ-018 pending SHALL be set in any cycle where key differs from the previous-cycle sampled key (prev_key register).
REQ-019 A key change during STREAM or DONE SHALL NOT alter cur_key; it sets pending, and the current frame SHALL complete before a new frame starts.
REQ-020 Multiple key changes during one frame SHALL result in exactly one following frame, using the key value latched at LOAD.
REQ-021 A key change in the same cycle as DONE SHALL be retained in pending and start the next frame from IDLE.
REQ-022 frame_busy SHALL be 1 in LOAD and STREAM, 0 in IDLE and DONE.
REQ-023 page/col counters SHALL be sized clog2(PAGES) and clog2(COLS) bits, minimum 1, and never exceed PAGES-1 / COLS-1.

Reset
REQ-024 While rst=1: state=IDLE, data_out=0x00, data_valid=0, frame_busy=0, frame_done=0, page=0, col=0, cur_key=0.
REQ-025 Reset SHALL set pending=1 and prev_key=key, so exactly one frame is streamed after reset releases without any key change.
REQ-026 Reset asserted mid-frame SHALL abandon the frame immediately; no further byte of it is offered.

Configuration
REQ-027 Macro LCD_FRAME_CNT_EN: when defined, the block adds output frame_cnt (8 bits), reset to 0 and incremented (wrapping 255 -> 0) in each frame_done cycle.
REQ-028 Without LCD_FRAME_CNT_EN, the port and its counter SHALL be absent; all other behaviour is identical.

Verification
REQ-029 Release reset with key=1, en=1 held -> 512 bytes of 0xFF on consecutive cycles, frame_done one cycle after the 512th, then data_valid=0.
REQ-030 key=2, en toggling 1/0 each cycle -> bytes 0x55,0xAA alternating per column, data_out stable during en=0, 512 transfers total.
REQ-031 key 5 then 9 changed at transfer 100 of a frame -> frame finishes with key 5 pattern (byte at page 1, col 3 = 0x23), then a full frame of 0x99.
REQ-032 Key changes 3->4->7 within one frame -> exactly one following frame, all bytes 0x77.
REQ-033 rst pulsed at transfer 200 -> data_valid=0 in the reset cycle; a fresh frame restarts at page 0, col 0.
REQ-034 With LCD_FRAME_CNT_EN defined, three frames -> frame_cnt=3; with 255 initial frames plus one -> frame_cnt=0.
